// File: rtl/brcomp_iter.sv
// Multi-cycle branch comparator: compares WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Optional macro BRCOMP_EARLY_EXIT_EN: finish on the first differing chunk instead of always scanning N chunks.
module brcomp_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] rs1_i,
   input  logic [WIDTH-1:0] rs2_i,
   input  logic             br_unsign_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             br_less_o,
   output logic             br_equal_o,
   output logic             busy_o
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             less_q, less_d, equal_q, equal_d;
`ifndef BRCOMP_EARLY_EXIT_EN
   logic             decided_q, decided_d, pend_less_q, pend_less_d;
`endif

   logic [WIDTH-1:0] sign_bias;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             chunk_lt, chunk_eq, last_chunk;

   function automatic logic [CHUNK-1:0] chunk_of(input logic [WIDTH-1:0] v,
                                                 input logic [KW-1:0]    k);
      chunk_of = v[int'(k)*CHUNK +: CHUNK];
   endfunction

   // Flipping the sign bit maps signed order onto unsigned order.
   assign sign_bias  = {~br_unsign_i, {(WIDTH-1){1'b0}}};
   assign a_chunk    = chunk_of(a_q, k_q);
   assign b_chunk    = chunk_of(b_q, k_q);
   assign chunk_lt   = (a_chunk < b_chunk);
   assign chunk_eq   = (a_chunk == b_chunk);
   assign last_chunk = (k_q == '0);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      less_d  = less_q;
      equal_d = equal_q;
`ifndef BRCOMP_EARLY_EXIT_EN
      decided_d   = decided_q;
      pend_less_d = pend_less_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               a_d     = rs1_i ^ sign_bias;
               b_d     = rs2_i ^ sign_bias;
               k_d     = KW'(N - 1);
               state_d = RUN;
`ifndef BRCOMP_EARLY_EXIT_EN
               decided_d   = 1'b0;
               pend_less_d = 1'b0;
`endif
            end
         end
         RUN: begin
`ifdef BRCOMP_EARLY_EXIT_EN
            if (!chunk_eq) begin
               less_d  = chunk_lt;
               equal_d = 1'b0;
               state_d = DONE;
            end else if (last_chunk) begin
               less_d  = 1'b0;
               equal_d = 1'b1;
               state_d = DONE;
            end else begin
               k_d = k_q - KW'(1);
            end
`else
            // Only the most significant differing chunk may set the verdict.
            if (!decided_q && !chunk_eq) begin
               decided_d   = 1'b1;
               pend_less_d = chunk_lt;
            end
            if (last_chunk) begin
               if (decided_q) begin
                  less_d  = pend_less_q;
                  equal_d = 1'b0;
               end else begin
                  less_d  = chunk_lt;
                  equal_d = chunk_eq;
               end
               state_d = DONE;
            end else begin
               k_d = k_q - KW'(1);
            end
`endif
         end
         DONE: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         less_q  <= 1'b0;
         equal_q <= 1'b0;
`ifndef BRCOMP_EARLY_EXIT_EN
         decided_q   <= 1'b0;
         pend_less_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         less_q  <= less_d;
         equal_q <= equal_d;
`ifndef BRCOMP_EARLY_EXIT_EN
         decided_q   <= decided_d;
         pend_less_q <= pend_less_d;
`endif
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign br_less_o   = less_q;
   assign br_equal_o  = equal_q;

endmodule

// File: tb/tb_brcomp_iter.sv
// Directed bench for brcomp_iter (WIDTH=32, CHUNK=8); latencies follow BRCOMP_EARLY_EXIT_EN.
module tb_brcomp_iter;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        unsign;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        less;
   logic        equal;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef BRCOMP_EARLY_EXIT_EN
   localparam int LTOP = 1;
   localparam int LCH1 = 3;
`else
   localparam int LTOP = 4;
   localparam int LCH1 = 4;
`endif

   brcomp_iter #(.WIDTH(32), .CHUNK(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .br_unsign_i (unsign),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .br_less_o   (less),
      .br_equal_o  (equal),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request, returns latency (-1 on timeout) and the result, then completes the handshake.
   task automatic do_compare(input logic [31:0] a, input logic [31:0] b, input logic uns,
                             output int lat, output logic l, output logic e);
      @(negedge clk);
      rs1 = a; rs2 = b; unsign = uns; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            lat = i;
            break;
         end
      end
      l = less;
      e = equal;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; rs1 = '0; rs2 = '0; unsign = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      checks++; if (less !== 1'b0)      begin errors++; $display("FAIL reset less: got %b expected 0", less); end
      checks++; if (equal !== 1'b0)     begin errors++; $display("FAIL reset equal: got %b expected 0", equal); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic run_table(input string name, input logic [31:0] va [4], input logic [31:0] vb [4],
                            input logic vu [4], input logic el [4], input logic ee [4], input int elat [4]);
      int   lat;
      logic l, e;
      for (int i = 0; i < 4; i++) begin
         do_compare(va[i], vb[i], vu[i], lat, l, e);
         checks++; if (lat !== elat[i]) begin errors++; $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, elat[i]); end
         checks++; if (l !== el[i])     begin errors++; $display("FAIL %s[%0d] less: got %b expected %b", name, i, l, el[i]); end
         checks++; if (e !== ee[i])     begin errors++; $display("FAIL %s[%0d] equal: got %b expected %b", name, i, e, ee[i]); end
      end
   endtask

   task automatic test_unsigned();
      logic [31:0] va [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5600};
      logic [31:0] vb [4] = '{32'h0000_0007, 32'h0000_0001, 32'h7FFF_FFFF, 32'h1234_5700};
      logic        vu [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      logic        el [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic        ee [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
      int          lt [4] = '{4, LTOP, LTOP, LCH1};
      run_table("unsigned", va, vb, vu, el, ee, lt);
   endtask

   task automatic test_signed();
      logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      logic [31:0] vb [4] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic        vu [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
      logic        el [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic        ee [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
      int          lt [4] = '{LTOP, LTOP, LTOP, 4};
      run_table("signed", va, vb, vu, el, ee, lt);
   endtask

   task automatic test_equal();
      logic [31:0] va [4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
      logic [31:0] vb [4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
      logic        vu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        el [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
      logic        ee [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      int          lt [4] = '{4, 4, 4, 4};
      run_table("equal", va, vb, vu, el, ee, lt);
   endtask

   task automatic test_backpressure();
      int lat;
      rsp_ready = 1'b0;
      @(negedge clk);
      rs1 = 32'h0000_0010; rs2 = 32'h0000_0020; unsign = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = i; break; end
      end
      checks++; if (lat !== 4)     begin errors++; $display("FAIL bp first latency: got %0d expected 4", lat); end
      checks++; if (less !== 1'b1) begin errors++; $display("FAIL bp first less: got %b expected 1", less); end
      rs1 = 32'h0000_0020; rs2 = 32'h0000_0010; req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp hold[%0d] rsp_valid: got %b expected 1", c, rsp_valid); end
         checks++; if (less !== 1'b1 || equal !== 1'b0) begin errors++; $display("FAIL bp hold[%0d] result: got less=%b equal=%b expected less=1 equal=0", c, less, equal); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp hold[%0d] req_ready: got %b expected 0", c, req_ready); end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp handshake: got rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready); end
      checks++; if (less !== 1'b1) begin errors++; $display("FAIL bp result held: got less=%b expected 1", less); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL bp second accept: got busy=%b req_ready=%b expected 1 0", busy, req_ready); end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = i; break; end
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL bp second latency: got %0d expected 4", lat); end
      checks++; if (less !== 1'b0 || equal !== 1'b0) begin errors++; $display("FAIL bp second result: got less=%b equal=%b expected 0 0", less, equal); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int   lat;
      int   pulses;
      logic l, e;
      do_compare(32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1, lat, l, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL rstmid pre equal: got %b expected 1", e); end
      @(negedge clk);
      rs1 = 32'hAABB_CCDD; rs2 = 32'hAABB_CCDD; unsign = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid busy before reset: got %b expected 1", busy); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rstmid control: got req_ready=%b rsp_valid=%b busy=%b expected 1 0 0", req_ready, rsp_valid, busy);
      end
      checks++; if (less !== 1'b0 || equal !== 1'b0) begin errors++; $display("FAIL rstmid result: got less=%b equal=%b expected 0 0", less, equal); end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid spurious rsp_valid: got %0d pulses expected 0", pulses); end
      do_compare(32'h0000_0010, 32'h0000_000F, 1'b1, lat, l, e);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid post latency: got %0d expected 4", lat); end
      checks++; if (l !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL rstmid post result: got less=%b equal=%b expected 0 0", l, e); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_equal();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
